// File: rtl/icb_copy_mst_if.sv
// ICB command/response channel bundle shared by masters (copy engine) and slaves (RAM, peripherals).
// The master drives commands and response-ready; the slave drives command-ready and responses.
interface icb_copy_mst_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_read;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/icb_copy_mst.sv
// ICB master word-copy engine: reads len words from src and writes them to dst, one
// transaction outstanding at a time, with a response watchdog and sticky error flag.
module icb_copy_mst #(
    parameter int LEN_W       = 16,
    parameter int TMO_CYC     = 255,
    parameter bit WAIT_WR_RSP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] cnt_o,
    icb_copy_mst_if.master   m_icb
);

    localparam int WD_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_RSP,
        S_WR_CMD,
        S_WR_RSP,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [WD_W-1:0]  wd_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             cmd_valid_q;
    logic             cmd_read_q;
    logic [31:0]      cmd_addr_q;
    logic [31:0]      cmd_wdata_q;
    logic [3:0]       cmd_wmask_q;
    logic             rsp_ready_q;

    logic             cmd_hs_d;
    logic [LEN_W-1:0] cnt_d;
    logic             last_d;
    logic [WD_W-1:0]  wd_d;
    logic             wd_expired_d;
    logic [31:0]      src_d;
    logic [31:0]      dst_d;

    always_comb begin
        cmd_hs_d     = cmd_valid_q & m_icb.cmd_ready;
        cnt_d        = cnt_q + LEN_W'(1);
        last_d       = (cnt_d == len_q);
        wd_d         = wd_q + WD_W'(1);
        wd_expired_d = (TMO_CYC != 0) && (wd_d == WD_W'(TMO_CYC));
        src_d        = src_q + 32'd4;
        dst_d        = dst_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_read_q  <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_wmask_q <= '0;
            rsp_ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        src_q  <= src_addr & 32'hFFFF_FFFC;
                        dst_q  <= dst_addr & 32'hFFFF_FFFC;
                        len_q  <= len_words;
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (len_words == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q     <= S_RD_CMD;
                            cmd_valid_q <= 1'b1;
                            cmd_read_q  <= 1'b1;
                            cmd_addr_q  <= src_addr & 32'hFFFF_FFFC;
                            cmd_wdata_q <= '0;
                            cmd_wmask_q <= '0;
                        end
                    end
                end

                S_RD_CMD: begin
                    if (cmd_hs_d) begin
                        state_q     <= S_RD_RSP;
                        cmd_valid_q <= 1'b0;
                        cmd_read_q  <= 1'b0;
                        cmd_addr_q  <= '0;
                        rsp_ready_q <= 1'b1;
                        wd_q        <= '0;
                    end
                end

                S_RD_RSP: begin
                    if (m_icb.rsp_valid) begin
                        rsp_ready_q <= 1'b0;
                        if (m_icb.rsp_err) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            // cmd_wdata_q doubles as the word buffer between read and write
                            state_q     <= S_WR_CMD;
                            cmd_valid_q <= 1'b1;
                            cmd_read_q  <= 1'b0;
                            cmd_addr_q  <= dst_q;
                            cmd_wdata_q <= m_icb.rsp_rdata;
                            cmd_wmask_q <= 4'hF;
                        end
                    end else if (wd_expired_d) begin
                        rsp_ready_q <= 1'b0;
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        wd_q <= wd_d;
                    end
                end

                S_WR_CMD: begin
                    if (cmd_hs_d) begin
                        cmd_valid_q <= 1'b0;
                        cmd_addr_q  <= '0;
                        cmd_wdata_q <= '0;
                        cmd_wmask_q <= '0;
                        if (WAIT_WR_RSP) begin
                            state_q     <= S_WR_RSP;
                            rsp_ready_q <= 1'b1;
                            wd_q        <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                            src_q <= src_d;
                            dst_q <= dst_d;
                            if (last_d) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                state_q     <= S_RD_CMD;
                                cmd_valid_q <= 1'b1;
                                cmd_read_q  <= 1'b1;
                                cmd_addr_q  <= src_d;
                            end
                        end
                    end
                end

                S_WR_RSP: begin
                    if (m_icb.rsp_valid) begin
                        rsp_ready_q <= 1'b0;
                        if (m_icb.rsp_err || last_d) begin
                            err_q   <= err_q | m_icb.rsp_err;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q     <= S_RD_CMD;
                            cmd_valid_q <= 1'b1;
                            cmd_read_q  <= 1'b1;
                            cmd_addr_q  <= src_d;
                        end
                        if (!m_icb.rsp_err) begin
                            cnt_q <= cnt_d;
                            src_q <= src_d;
                            dst_q <= dst_d;
                        end
                    end else if (wd_expired_d) begin
                        rsp_ready_q <= 1'b0;
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        wd_q <= wd_d;
                    end
                end

                S_DONE: begin
                    // A zero-length copy arrives here with busy set and done clear:
                    // it spends one busy cycle, then pulses done like any other copy.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign cnt_o           = cnt_q;
    assign m_icb.cmd_valid = cmd_valid_q;
    assign m_icb.cmd_read  = cmd_read_q;
    assign m_icb.cmd_addr  = cmd_addr_q;
    assign m_icb.cmd_wdata = cmd_wdata_q;
    assign m_icb.cmd_wmask = cmd_wmask_q;
    assign m_icb.rsp_ready = rsp_ready_q;

endmodule

// File: tb/tb_icb_copy_mst.sv
// Bench for icb_copy_mst: a behavioural ICB slave logs every command it accepts; each copy
// pushes its expected reads/writes into queues and pops them against the log afterwards.
module tb_icb_copy_mst;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len_words = '0;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [LEN_W-1:0] cnt_o;

    icb_copy_mst_if m_icb ();

    icb_copy_mst #(
        .LEN_W      (LEN_W),
        .TMO_CYC    (8),
        .WAIT_WR_RSP(1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len_words(len_words),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .cnt_o    (cnt_o),
        .m_icb    (m_icb.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // ---------------- slave model ----------------
    logic [31:0] mem [logic [31:0]];
    bit          mute = 1'b0;
    bit          stray = 1'b0;
    int          err_at_read = 0;
    int          stall_at_wr = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          stall_cnt = 0;
    int          rd_hs_edge = 0;
    logic [67:0] obs_rd_q[$];
    logic [67:0] obs_wr_q[$];
    logic [67:0] obs_stall_q[$];
    int          rd_seen = 0;
    int          wr_seen = 0;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    initial begin : slave
        logic        hs;
        logic        rd;
        logic [31:0] a;
        logic [67:0] f;
        m_icb.cmd_ready = 1'b1;
        m_icb.rsp_valid = 1'b0;
        m_icb.rsp_err   = 1'b0;
        m_icb.rsp_rdata = '0;
        forever begin
            @(negedge clk);
            hs = m_icb.cmd_valid && m_icb.cmd_ready;
            rd = m_icb.cmd_read;
            a  = m_icb.cmd_addr;
            f  = {m_icb.cmd_addr, m_icb.cmd_wdata, m_icb.cmd_wmask};
            if (m_icb.cmd_valid && !m_icb.cmd_ready && !rd) obs_stall_q.push_back(f);
            @(posedge clk);
            #1;
            m_icb.rsp_valid = stray;
            m_icb.rsp_err   = 1'b0;
            m_icb.rsp_rdata = '0;
            if (hs) begin
                if (rd) begin
                    n_rd++;
                    obs_rd_q.push_back(f);
                    rd_hs_edge = cyc;
                    if (!mute) begin
                        m_icb.rsp_valid = 1'b1;
                        m_icb.rsp_rdata = rd_val(a);
                        m_icb.rsp_err   = (n_rd == err_at_read);
                    end
                end else begin
                    n_wr++;
                    obs_wr_q.push_back(f);
                end
            end
            if (m_icb.cmd_valid && !m_icb.cmd_read && (n_wr + 1 == stall_at_wr) && stall_cnt < 5) begin
                m_icb.cmd_ready = 1'b0;
                stall_cnt++;
            end else begin
                m_icb.cmd_ready = 1'b1;
            end
        end
    end

    function automatic logic [127:0] out_bundle();
        return 128'({busy_o, done_o, err_o, cnt_o, m_icb.cmd_valid, m_icb.cmd_read,
                     m_icb.cmd_addr, m_icb.cmd_wdata, m_icb.cmd_wmask, m_icb.rsp_ready});
    endfunction

    // ---------------- one copy with scoreboard ----------------
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int len,
                            input int n_rd_exp, input int n_wr_exp, input bit exp_err,
                            input int exp_cnt, input int exp_lat,
                            output int busy_n, output int done_cyc);
        logic [67:0] exp_rd_q[$];
        logic [67:0] exp_wr_q[$];
        logic [31:0] s_al;
        logic [31:0] d_al;
        int          lat;
        s_al = s & 32'hFFFF_FFFC;
        d_al = d & 32'hFFFF_FFFC;
        for (int i = 0; i < n_rd_exp; i++) exp_rd_q.push_back({s_al + 32'(4 * i), 32'h0, 4'h0});
        for (int i = 0; i < n_wr_exp; i++)
            exp_wr_q.push_back({d_al + 32'(4 * i), rd_val(s_al + 32'(4 * i)), 4'hF});

        @(posedge clk);
        #1;
        start = 1'b1; src_addr = s; dst_addr = d; len_words = LEN_W'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        busy_n = 0;
        @(negedge clk);
        check_eq("err_clr_on_start", 128'(err_o), 128'd0);
        while (!done_o && lat < 300) begin
            if (busy_o) busy_n++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        done_cyc = cyc;
        check_eq("done_seen", 128'(done_o), 128'd1);
        if (exp_lat > 0) check_eq("done_latency", 128'(lat), 128'(exp_lat));
        check_eq("busy_at_done", 128'(busy_o), 128'd0);
        check_eq("err", 128'(err_o), 128'(exp_err));
        check_eq("cnt", 128'(cnt_o), 128'(exp_cnt));
        $display("copy src=%08h dst=%08h len=%0d lat=%0d err=%0b cnt=%0d", s, d, len, lat, err_o, cnt_o);
        @(negedge clk);
        check_eq("done_one_cycle", 128'(done_o), 128'd0);

        check_eq("rd_count", 128'(obs_rd_q.size() - rd_seen), 128'(n_rd_exp));
        while (exp_rd_q.size() > 0 && rd_seen < obs_rd_q.size()) begin
            check_eq("rd_cmd", 128'(obs_rd_q[rd_seen]), 128'(exp_rd_q.pop_front()));
            rd_seen++;
        end
        rd_seen = obs_rd_q.size();
        check_eq("wr_count", 128'(obs_wr_q.size() - wr_seen), 128'(n_wr_exp));
        while (exp_wr_q.size() > 0 && wr_seen < obs_wr_q.size()) begin
            check_eq("wr_cmd", 128'(obs_wr_q[wr_seen]), 128'(exp_wr_q.pop_front()));
            wr_seen++;
        end
        wr_seen = obs_wr_q.size();
    endtask

    initial begin : global_guard
        #500000;
        $display("FAIL global_timeout: got cyc=%0d expected end of test", cyc);
        $fatal(1);
    end

    initial begin : main
        int busy_n;
        int done_cyc;
        bit any_done;

        repeat (3) @(negedge clk);
        check_eq("reset_outputs", out_bundle(), 128'd0);
        rst = 1'b0;

        // basic copy with spec data
        mem[32'h0800_0000] = 32'hA0;
        mem[32'h0800_0004] = 32'hA1;
        mem[32'h0800_0008] = 32'hA2;
        run_copy(32'h0800_0000, 32'h0000_0100, 3, 3, 3, 1'b0, 3, 10, busy_n, done_cyc);

        // zero-length copy
        run_copy(32'h0800_0000, 32'h0000_0100, 0, 0, 0, 1'b0, 0, 2, busy_n, done_cyc);
        check_eq("len0_busy_cycles", 128'(busy_n), 128'd1);

        // backpressure on the first write
        stall_at_wr = n_wr + 1;
        run_copy(32'h0000_3000, 32'h0000_4000, 2, 2, 2, 1'b0, 2, -1, busy_n, done_cyc);
        check_eq("stall_cycles", 128'(stall_cnt), 128'd5);
        for (int i = 0; i < obs_stall_q.size(); i++)
            check_eq("stall_hold", 128'(obs_stall_q[i]), 128'({32'h0000_4000, rd_val(32'h0000_3000), 4'hF}));

        // read error on the second read
        err_at_read = n_rd + 2;
        run_copy(32'h0000_5000, 32'h0000_6000, 4, 2, 1, 1'b1, 1, -1, busy_n, done_cyc);
        err_at_read = 0;

        // next start clears err_o; two words take 1 + 2*3 cycles
        run_copy(32'h0000_7000, 32'h0000_7800, 2, 2, 2, 1'b0, 2, 7, busy_n, done_cyc);

        // slave never responds: watchdog abort, then a stray response is ignored
        mute = 1'b1;
        run_copy(32'h0000_9000, 32'h0000_A000, 2, 1, 0, 1'b1, 0, -1, busy_n, done_cyc);
        check_eq("tmo_latency", 128'(done_cyc - rd_hs_edge), 128'd8);
        mute = 1'b0;
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        check_eq("stray_rsp_ready", 128'(m_icb.rsp_ready), 128'd0);
        repeat (2) @(negedge clk);
        check_eq("stray_ignored", 128'({busy_o, done_o, err_o, m_icb.cmd_valid}), 128'(4'b0010));

        // source address wraps past the top of the address space
        run_copy(32'hFFFF_FFFD, 32'h0000_2000, 2, 2, 2, 1'b0, 2, -1, busy_n, done_cyc);

        // reset while waiting in RD_RSP
        mute = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1; src_addr = 32'h0000_B000; dst_addr = 32'h0000_C000; len_words = LEN_W'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 20 && obs_rd_q.size() == rd_seen; k++) @(negedge clk);
        @(negedge clk);
        check_eq("rst_rd_issued", 128'(obs_rd_q.size() - rd_seen), 128'd1);
        check_eq("rst_in_rd_rsp", 128'({busy_o, m_icb.rsp_ready}), 128'(2'b11));
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_outputs", out_bundle(), 128'd0);
        rst = 1'b0;
        any_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_done |= done_o;
        end
        check_eq("rst_no_done", 128'(any_done), 128'd0);
        rd_seen = obs_rd_q.size();
        wr_seen = obs_wr_q.size();
        mute = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
